// File: rtl/ext_irq_ctrl.sv
// External interrupt controller with per-source enable, edge/level mode, priority and claim/complete.
// Latency: irq_source -> irq_q -> pending -> outputs over three edges; reads return next cycle; the bus never stalls.
typedef struct packed {
   logic [31:0] waddr;
   logic [31:0] raddr;
   logic [31:0] wdata;
} hb_slave_t;

typedef struct packed {
   logic wen;
   logic ren;
} sel_t;

module ext_irq_ctrl #(
   parameter int INT_NUM   = 32,
   parameter int PRIO_BITS = 3
) (
   input  logic               hb_clk,
   input  logic               rst_sync_n,
   input  hb_slave_t          xt_hb,
   input  sel_t               sel,
   output logic [31:0]        rdata,
   input  logic [INT_NUM-1:0] irq_source,
   output logic [26:0]        custom_int_code,
   output logic               mextern_int
);

   localparam logic [3:0] A_ENABLE  = 4'd0;
   localparam logic [3:0] A_PENDING = 4'd1;
   localparam logic [3:0] A_MODE    = 4'd2;
   localparam logic [3:0] A_THRESH  = 4'd3;
   localparam logic [3:0] A_CLAIM   = 4'd4;

   logic [INT_NUM-1:0]   enable, mode, pending, in_service, irq_q, irq_prev;
   logic [PRIO_BITS-1:0] threshold;
   logic [PRIO_BITS-1:0] prio [INT_NUM];

   logic [3:0]  wsel, rsel;
   logic        wr_enable, wr_pend, wr_mode, wr_thr, wr_cmp, wr_prio, rd_claim;
   logic [INT_NUM-1:0] w1c, mode_chg, edge_set, eligible, claim_vec, cmp_vec, pend_nxt;
   logic [5:0]           win_id;
   logic [PRIO_BITS-1:0] win_prio;
   logic [31:0]          rd_mux;
   logic                 unused_addr;

   assign wsel = xt_hb.waddr[5:2];
   assign rsel = xt_hb.raddr[5:2];
   assign unused_addr = ^{xt_hb.waddr[31:6], xt_hb.waddr[1:0], xt_hb.raddr[31:6], xt_hb.raddr[1:0]};

   assign wr_enable = sel.wen && (wsel == A_ENABLE);
   assign wr_pend   = sel.wen && (wsel == A_PENDING);
   assign wr_mode   = sel.wen && (wsel == A_MODE);
   assign wr_thr    = sel.wen && (wsel == A_THRESH);
   assign wr_cmp    = sel.wen && (wsel == A_CLAIM);
   assign wr_prio   = sel.wen && (wsel[3:2] == 2'b10);
   assign rd_claim  = sel.ren && (rsel == A_CLAIM);

   assign w1c      = wr_pend ? xt_hb.wdata[INT_NUM-1:0] : '0;
   assign mode_chg = wr_mode ? (mode ^ xt_hb.wdata[INT_NUM-1:0]) : '0;
   assign edge_set = irq_q & ~irq_prev & enable;

   always_comb begin
      eligible  = '0;
      claim_vec = '0;
      cmp_vec   = '0;
      pend_nxt  = '0;
      for (int i = 0; i < INT_NUM; i++) begin
         eligible[i]  = pending[i] & enable[i] & ~in_service[i] & (prio[i] != '0);
         claim_vec[i] = rd_claim && (win_id == 6'(i + 1));
         cmp_vec[i]   = wr_cmp && (xt_hb.wdata == 32'(i + 1));
         // Edge set beats any clear on the same edge; level sources freeze while in service.
         if (mode[i])
            pend_nxt[i] = edge_set[i] | (pending[i] & ~w1c[i] & ~claim_vec[i]);
         else if (!in_service[i])
            pend_nxt[i] = irq_q[i] & enable[i];
         else
            pend_nxt[i] = pending[i] & ~w1c[i];
         if (mode_chg[i])
            pend_nxt[i] = 1'b0;
      end
   end

   // Scan from the top ID down with >= so equal priorities resolve to the lowest ID.
   always_comb begin
      win_id   = '0;
      win_prio = '0;
      for (int i = INT_NUM - 1; i >= 0; i--) begin
         if (eligible[i] && (prio[i] >= win_prio)) begin
            win_id   = 6'(i + 1);
            win_prio = prio[i];
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (rsel)
         A_ENABLE:  rd_mux = 32'(enable);
         A_PENDING: rd_mux = 32'(pending);
         A_MODE:    rd_mux = 32'(mode);
         A_THRESH:  rd_mux = 32'(threshold);
         A_CLAIM:   rd_mux = 32'(win_id);
         4'd8, 4'd9, 4'd10, 4'd11: begin
            for (int i = 0; i < INT_NUM; i++) begin
               if (rsel[1:0] == 2'(i / 8))
                  rd_mux[4*(i%8) +: PRIO_BITS] = prio[i];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge hb_clk) begin
      if (!rst_sync_n) begin
         enable          <= '0;
         mode            <= '0;
         threshold       <= '0;
         pending         <= '0;
         in_service      <= '0;
         irq_q           <= '0;
         irq_prev        <= '0;
         rdata           <= '0;
         custom_int_code <= '0;
         mextern_int     <= 1'b0;
         for (int i = 0; i < INT_NUM; i++)
            prio[i] <= '0;
      end else begin
         irq_q      <= irq_source;
         irq_prev   <= irq_q;
         pending    <= pend_nxt;
         // Complete is applied after claim so a same-cycle claim+complete leaves the source idle.
         in_service <= (in_service | claim_vec) & ~cmp_vec;
         if (wr_enable)
            enable <= xt_hb.wdata[INT_NUM-1:0];
         if (wr_mode)
            mode <= xt_hb.wdata[INT_NUM-1:0];
         if (wr_thr)
            threshold <= xt_hb.wdata[PRIO_BITS-1:0];
         for (int i = 0; i < INT_NUM; i++) begin
            if (wr_prio && (wsel[1:0] == 2'(i / 8)))
               prio[i] <= xt_hb.wdata[4*(i%8) +: PRIO_BITS];
         end
         if (sel.ren)
            rdata <= rd_mux;
         custom_int_code <= {21'b0, win_id};
         mextern_int     <= (win_id != '0) && (win_prio > threshold);
      end
   end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed and randomized checks of ext_irq_ctrl against a score-based priority model.
module tb_ext_irq_ctrl;

   logic        hb_clk = 1'b0;
   logic        rst_sync_n;
   hb_slave_t   xt_hb;
   sel_t        sel;
   logic [31:0] rdata;
   logic [31:0] irq_source;
   logic [26:0] custom_int_code;
   logic        mextern_int;

   int total = 0;
   int bad   = 0;

   int m_en   [32];
   int m_prio [32];
   int m_pend [32];
   int m_ins  [32];
   int m_thr;

   ext_irq_ctrl #(.INT_NUM(32), .PRIO_BITS(3)) dut (
      .hb_clk          (hb_clk),
      .rst_sync_n      (rst_sync_n),
      .xt_hb           (xt_hb),
      .sel             (sel),
      .rdata           (rdata),
      .irq_source      (irq_source),
      .custom_int_code (custom_int_code),
      .mextern_int     (mextern_int)
   );

   always #5 hb_clk = ~hb_clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge hb_clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      xt_hb.waddr = a;
      xt_hb.wdata = d;
      sel.wen = 1'b1;
      tick(1);
      sel.wen = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      xt_hb.raddr = a;
      sel.ren = 1'b1;
      tick(1);
      sel.ren = 1'b0;
      d = rdata;
   endtask

   // Winner = largest score prio*64 + (64 - id): priority dominates, lower ID breaks ties.
   function automatic int model_win();
      int best;
      int id;
      int score;
      best = 0;
      id   = 0;
      for (int s = 1; s <= 32; s++) begin
         if (m_pend[s-1] != 0 && m_en[s-1] != 0 && m_ins[s-1] == 0 && m_prio[s-1] != 0) begin
            score = m_prio[s-1] * 64 + (64 - s);
            if (score > best) begin
               best = score;
               id   = s;
            end
         end
      end
      return id;
   endfunction

   initial begin
      logic [31:0] d;
      logic [31:0] irq_v, en_v, pend_v;
      logic [31:0] w [4];
      int wid, wid2, mx;

      rst_sync_n = 1'b0;
      xt_hb      = '0;
      sel        = '0;
      irq_source = '0;
      tick(2);
      chk("rst_rdata", rdata, 0);
      chk("rst_code", 32'(custom_int_code), 0);
      chk("rst_mext", 32'(mextern_int), 0);
      rst_sync_n = 1'b1;
      rd(32'h00, d); chk("rst_enable", d, 0);

      wr(32'h20, 32'hFFFF_FFFF); rd(32'h20, d); chk("prio_mask", d, 32'h7777_7777);
      wr(32'h0C, 32'hFF);        rd(32'h0C, d); chk("thr_mask", d, 7);
      wr(32'h14, 32'hFFFF_FFFF); rd(32'h14, d); chk("unmapped", d, 0);

      // Single level source, latency in both directions
      wr(32'h00, 1); wr(32'h20, 3); wr(32'h0C, 0);
      irq_source = 32'h1;
      tick(2); chk("lvl_early", 32'(custom_int_code), 0);
      tick(1); chk("lvl_code", 32'(custom_int_code), 1);
      chk("lvl_mext", 32'(mextern_int), 1);
      irq_source = 32'h0;
      tick(2); chk("lvl_hold", 32'(mextern_int), 1);
      tick(1); chk("lvl_drop", 32'(mextern_int), 0);

      // Priority ordering with claim/complete and ignored completes
      wr(32'h00, 32'hFFFF_FFFF); wr(32'h20, 32'h0005_0200);
      irq_source = 32'h14;
      tick(3); chk("pri_code", 32'(custom_int_code), 5);
      rd(32'h10, d); chk("pri_claim", d, 5);
      tick(1); chk("pri_next", 32'(custom_int_code), 3);
      wr(32'h10, 5);
      tick(1); chk("pri_back", 32'(custom_int_code), 5);
      rd(32'h10, d); chk("pri_claim2", d, 5);
      wr(32'h10, 0); wr(32'h10, 33); wr(32'h10, 3);
      tick(1); chk("bad_complete", 32'(custom_int_code), 3);
      wr(32'h10, 5);
      tick(1); chk("pri_back2", 32'(custom_int_code), 5);
      irq_source = 32'h0;
      tick(3); chk("pri_idle", 32'(custom_int_code), 0);

      // Tie and threshold
      wr(32'h20, 32'h0000_4040); wr(32'h0C, 4);
      irq_source = 32'h0A;
      tick(3); chk("tie_code", 32'(custom_int_code), 2);
      chk("thr_block", 32'(mextern_int), 0);
      wr(32'h0C, 3);
      tick(1); chk("thr_pass", 32'(mextern_int), 1);
      irq_source = 32'h0;
      wr(32'h0C, 0);

      // Edge source
      wr(32'h20, 32'h0300_0000); wr(32'h08, 32'h40);
      tick(3);
      irq_source = 32'h40; tick(1); irq_source = 32'h0; tick(3);
      rd(32'h04, d); chk("edge_pend", d, 32'h40);
      chk("edge_code", 32'(custom_int_code), 7);
      rd(32'h10, d); chk("edge_claim", d, 7);
      rd(32'h04, d); chk("edge_clr", d, 0);
      irq_source = 32'h40; tick(1); irq_source = 32'h0; tick(3);
      rd(32'h04, d); chk("edge_insvc_pend", d, 32'h40);
      chk("edge_insvc_code", 32'(custom_int_code), 0);
      wr(32'h10, 7);
      tick(1); chk("edge_done", 32'(custom_int_code), 7);
      wr(32'h04, 32'h40); rd(32'h04, d); chk("w1c", d, 0);
      irq_source = 32'h40; tick(1); irq_source = 32'h0;
      wr(32'h04, 32'h40); rd(32'h04, d); chk("w1c_vs_set", d, 32'h40);
      wr(32'h08, 32'h41); rd(32'h04, d); chk("mode_other", d, 32'h40);
      rd(32'h10, d); chk("edge_claim3", d, 7);
      irq_source = 32'h40; tick(1); irq_source = 32'h0; tick(2);
      rd(32'h04, d); chk("edge_relatch", d, 32'h40);
      wr(32'h08, 32'h01); rd(32'h04, d); chk("mode_toggle_clr", d, 0);
      rd(32'h08, d); chk("mode_read", d, 1);
      wr(32'h10, 7); wr(32'h08, 0);

      // Reset while a claim is outstanding
      wr(32'h20, 32'h0000_0033);
      irq_source = 32'h3;
      tick(3); chk("rs_code", 32'(custom_int_code), 1);
      rd(32'h10, d); chk("rs_claim", d, 1);
      tick(1); chk("rs_mext", 32'(mextern_int), 1);
      rst_sync_n = 1'b0;
      tick(1);
      chk("rs_mext0", 32'(mextern_int), 0);
      chk("rs_code0", 32'(custom_int_code), 0);
      chk("rs_rdata0", rdata, 0);
      rst_sync_n = 1'b1;
      rd(32'h00, d); chk("rs_enable", d, 0);
      rd(32'h20, d); chk("rs_prio", d, 0);
      rd(32'h10, d); chk("rs_claim0", d, 0);
      irq_source = 32'h0;

      // Randomized level-mode configurations
      for (int it = 0; it < 20; it++) begin
         irq_v = $urandom;
         en_v  = $urandom;
         m_thr = int'($urandom_range(0, 7));
         for (int k = 0; k < 4; k++) w[k] = '0;
         for (int s = 0; s < 32; s++) begin
            m_en[s]   = int'(en_v[s]);
            m_prio[s] = int'($urandom_range(0, 7));
            m_ins[s]  = 0;
            w[s/8]    = w[s/8] | (32'(m_prio[s]) << (4 * (s % 8)));
         end
         irq_source = irq_v;
         wr(32'h00, en_v);
         wr(32'h0C, 32'(m_thr));
         for (int k = 0; k < 4; k++) wr(32'h20 + 32'(4 * k), w[k]);
         tick(3);
         pend_v = irq_v & en_v;
         for (int s = 0; s < 32; s++) m_pend[s] = int'(pend_v[s]);
         wid = model_win();
         mx  = 0;
         if (wid != 0 && m_prio[wid-1] > m_thr) mx = 1;
         chk("rnd_code", 32'(custom_int_code), 32'(wid));
         chk("rnd_mext", 32'(mextern_int), 32'(mx));
         rd(32'h04, d); chk("rnd_pend", d, pend_v);
         rd(32'h10, d); chk("rnd_claim", d, 32'(wid));
         if (wid != 0) m_ins[wid-1] = 1;
         tick(1);
         wid2 = model_win();
         chk("rnd_next", 32'(custom_int_code), 32'(wid2));
         wr(32'h10, 32'(wid));
         if (wid != 0) m_ins[wid-1] = 0;
         tick(1);
         chk("rnd_back", 32'(custom_int_code), 32'(model_win()));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ext_irq_ctrl.md
EXT_IRQ_CTRL -- requirements
Module: ext_irq_ctrl

Interface
REQ-001 SHALL have parameter INT_NUM, default 32, number of interrupt sources (legal 1..32).
REQ-002 SHALL have parameter PRIO_BITS, default 3, priority field width per source (legal 1..4).
REQ-003 SHALL have port hb_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_sync_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port xt_hb  input  hb_slave_t  bus slave bundle; uses waddr, raddr, wdata.
REQ-006 SHALL have port sel  input  sel_t  decoded select; uses wen, ren.
REQ-007 SHALL have port rdata  output  32  registered read data.
REQ-008 SHALL have port irq_source  input  INT_NUM  raw interrupt requests, bit i = source ID i+1.
REQ-009 SHALL have port custom_int_code  output  27  {21'b0, 6-bit winning ID}, 0 = none.
REQ-010 SHALL have port mextern_int  output  1  machine external interrupt request to core.

Function
REQ-011 SHALL decode address bits [5:2]: 0 ENABLE, 1 PENDING, 2 MODE, 3 THRESHOLD, 4 CLAIM/COMPLETE, 8..11 PRIO word k (8 sources x 4-bit nibbles, source 8k+j in bits [4j+3:4j]).
REQ-012 SHALL store only PRIO_BITS LSBs of each nibble and PRIO_BITS LSBs of THRESHOLD; unimplemented bits and unmapped addresses read 0, writes ignored.
REQ-013 SHALL register irq_source into irq_q and irq_q into irq_prev every cycle.
REQ-014 MODE bit 1 = rising-edge source: pending set when irq_q & ~irq_prev & enable.
REQ-015 MODE bit 0 = level source: pending <= irq_q & enable each cycle, while not in service.
REQ-016 Edge pending SHALL hold until claim or write-1-to-clear on PENDING; set in same cycle as clear SHALL win.
REQ-017 Writing MODE SHALL clear pending of every source whose mode bit changes.
REQ-018 Eligible = pending & ENABLE & ~in_service & (priority != 0).
REQ-019 Winner = eligible source with highest priority; tie -> lowest ID.
REQ-020 mextern_int and custom_int_code SHALL be registered from winner: mextern_int = 1 iff winner priority > THRESHOLD; custom_int_code = winner ID if any eligible, else 0.
REQ-021 Latency: irq_source high before edge E0 -> pending after E1 -> mextern_int/custom_int_code after E2.
REQ-022 Read of CLAIM (sel.ren, addr 4) SHALL return current winner ID (0 if none) in rdata next cycle, set in_service[ID-1], clear that source's edge pending, same edge.
REQ-023 Claim with ID 0 SHALL have no side effect.
REQ-024 Write of CLAIM SHALL clear in_service[wdata-1]; ignored if wdata = 0, > INT_NUM, or not in service.
REQ-025 In-service source SHALL still latch new edges into pending but not be eligible until completed.
REQ-026 Claim and complete same cycle for the same ID: complete SHALL win (in_service ends 0).
REQ-027 All reads SHALL update rdata one cycle after sel.ren; rdata holds when ren low; PENDING read returns raw pending.
REQ-028 Simultaneous wen and ren SHALL be honoured independently.

Reset
REQ-029 rst_sync_n = 0 at an edge SHALL zero ENABLE, MODE, THRESHOLD, all priorities, pending, in_service, irq_q, irq_prev, rdata, custom_int_code, mextern_int.
REQ-030 Reset mid-operation SHALL abandon all claims; no output asserts until 2 edges after new pending forms.

Verification
REQ-031 Level: INT_NUM=32, ENABLE=1, PRIO0=3, THRESHOLD=0, irq_source[0]=1 -> mextern_int=1, code=1 two edges later; deassert source -> mextern_int=0 two edges later.
REQ-032 Priority: sources 3 (prio 2) and 5 (prio 5) pending -> code=5; claim returns 5; code becomes 3 two edges later; complete 5 -> code=5 again if still level-high.
REQ-033 Tie/threshold: sources 2 and 4 both prio 4, THRESHOLD=4 -> code=2, mextern_int=0; THRESHOLD=3 -> mextern_int=1.
REQ-034 Edge: MODE[6]=1, 1-cycle pulse on irq_source[6] -> PENDING bit 6 stays 1; claim returns 7 and clears it; second pulse during service -> pending 1, code 0 until complete of 7.
REQ-035 Boundaries: complete with 0, 33, non-serviced ID -> no change; W1C and edge same cycle -> pending stays 1; MODE toggle clears pending.
REQ-036 Reset during service with mextern_int=1 -> all registers 0 after edge, mextern_int=0, claim returns 0.
